tb04_outi_fifo: RTL and testbench

- Sits directly upstream of the UART byte transmitter, between the TB-04 CPU OUT port and the transmitter's nibble input.
- Assembles pairs of OUTI nibbles (CPU `wo` + `out[3:0]`) into bytes and buffers them in a FIFO.
- Replays each byte to the transmitter as two paced nibble strobes, only when the transmitter's busy flag, synchronized into this domain, is low.
- Removes the dropped-byte hazard when the CPU writes faster than the UART line rate.

---
 rtl/tb04_outi_fifo_if.sv | 29 ++
 rtl/tb04_outi_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_tb04_outi_fifo.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb04_outi_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb04_outi_fifo_if : CPU OUT-port / UART nibble handshake bundle       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface tb04_outi_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              cpu_wo;
  logic [3:0]        cpu_out;
  logic              uart_busy;
  logic              tx_wo;
  logic [3:0]        tx_nib;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;

  modport master (
    output cpu_wo, cpu_out, uart_busy,
    input  tx_wo, tx_nib, fifo_level, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  cpu_wo, cpu_out, uart_busy,
    output tx_wo, tx_nib, fifo_level, fifo_full, fifo_empty, overflow
  );
endinterface
`default_nettype wire

// File: rtl/tb04_outi_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb04_outi_fifo : pairs OUTI nibbles into bytes, buffers them and      |
// | replays paced nibble strobes to the UART transmitter when not busy.   |
// | Optional half-byte timeout: define TB04_NIB_RESYNC_EN.                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb04_outi_fifo #(
  parameter int ADDR_W     = 4,
  parameter int GAP_CYC    = 2,
  parameter int HOLD_CYC   = 4,
  parameter int RESYNC_CYC = 1024
) (
  input  logic                tb04_clk,
  input  logic                rst,
  tb04_outi_fifo_if.slave     bus
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int CNT_MAX = (GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_GAP  = 3'd2,
    S_LO   = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  logic               busy_meta_q, busy_s_q;
  logic               half_q, half_d;
  logic [3:0]         hi_q, hi_d;
  logic               push_req;
  logic               push, pop;
  logic               full, empty;
  logic               timeout;

  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]    level_q, level_d;
  logic               overflow_q;
  logic [7:0]         rd_data;

  state_t             state_q, state_d;
  logic [3:0]         cur_lo_q, cur_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_wo_q, tx_wo_d;
  logic [3:0]         tx_nib_q, tx_nib_d;

  // Busy comes from the 12 MHz domain; flops reset to 1 so nothing is sent
  // until the transmitter has been observed idle.
  always_ff @(posedge tb04_clk or posedge rst) begin
    if (rst) begin
      busy_meta_q <= 1'b1;
      busy_s_q    <= 1'b1;
    end else begin
      busy_meta_q <= bus.uart_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

`ifdef TB04_NIB_RESYNC_EN
  localparam int RS_W = $clog2(RESYNC_CYC + 1);
  logic [RS_W-1:0] rs_cnt_q;

  always_ff @(posedge tb04_clk or posedge rst) begin
    if (rst) begin
      rs_cnt_q <= '0;
    end else if (bus.cpu_wo || !half_q || timeout) begin
      rs_cnt_q <= '0;
    end else begin
      rs_cnt_q <= rs_cnt_q + 1'b1;
    end
  end

  assign timeout = half_q && (rs_cnt_q == RS_W'(RESYNC_CYC));
`else
  assign timeout = (RESYNC_CYC < 0);
`endif

  // A wo in the timeout cycle starts a fresh byte instead of completing one.
  always_comb begin
    half_d   = half_q;
    hi_d     = hi_q;
    push_req = 1'b0;
    if (timeout) begin
      half_d = 1'b0;
    end
    if (bus.cpu_wo) begin
      if (half_q && !timeout) begin
        push_req = 1'b1;
        half_d   = 1'b0;
      end else begin
        hi_d   = bus.cpu_out;
        half_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tb04_clk or posedge rst) begin
    if (rst) begin
      half_q <= 1'b0;
      hi_q   <= 4'h0;
    end else begin
      half_q <= half_d;
      hi_q   <= hi_d;
    end
  end

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign pop     = (state_q == S_IDLE) && !empty && !busy_s_q;
  assign push    = push_req && (!full || pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge tb04_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {hi_q, bus.cpu_out};
    end
  end

  always_ff @(posedge tb04_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      if (push_req && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Strobes are registered: the strobe for a state is decided on its entry.
  always_comb begin
    state_d  = state_q;
    cur_lo_d = cur_lo_q;
    cnt_d    = cnt_q;
    tx_wo_d  = 1'b0;
    tx_nib_d = tx_nib_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_lo_d = rd_data[3:0];
          tx_wo_d  = 1'b1;
          tx_nib_d = rd_data[7:4];
          state_d  = S_HI;
        end
      end
      S_HI: begin
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          tx_wo_d  = 1'b1;
          tx_nib_d = cur_lo_q;
          state_d  = S_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LO: begin
        cnt_d   = HOLD_LOAD;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge tb04_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_lo_q <= 4'h0;
      cnt_q    <= '0;
      tx_wo_q  <= 1'b0;
      tx_nib_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      cur_lo_q <= cur_lo_d;
      cnt_q    <= cnt_d;
      tx_wo_q  <= tx_wo_d;
      tx_nib_q <= tx_nib_d;
    end
  end

  assign bus.tx_wo      = tx_wo_q;
  assign bus.tx_nib     = tx_nib_q;
  assign bus.fifo_level = level_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_tb04_outi_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tb04_outi_fifo : self-checking bench for tb04_outi_fifo            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_tb04_outi_fifo;

  localparam int ADDR_W = 4;

  logic tb04_clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tx_cnt  = 0;
  logic prev_wo = 1'b0;
  logic [3:0] sb [$];

  tb04_outi_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  tb04_outi_fifo #(
    .ADDR_W     (ADDR_W),
    .GAP_CYC    (2),
    .HOLD_CYC   (4),
    .RESYNC_CYC (8)
  ) dut (
    .tb04_clk (tb04_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 tb04_clk = ~tb04_clk;

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    int         spacing;
    int         exp_lat;
    int         exp_gap;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb04_clk);
    #1;
  endtask

  // Called just after a posedge; the nibble is sampled at the next edge.
  task automatic send_nib(input logic [3:0] n);
    bus.cpu_wo  = 1'b1;
    bus.cpu_out = n;
    tick();
    bus.cpu_wo  = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge tb04_clk);
      if (tx_cnt >= target) break;
    end
    check("wait_tx_reached", int'(tx_cnt >= target), 1);
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (sb.size() == 0 && bus.fifo_empty) break;
      tick();
    end
    repeat (12) tick();
    check("drain_sb_empty", sb.size(), 0);
    check("drain_fifo_empty", int'(bus.fifo_empty), 1);
  endtask

  // Scoreboard consumer: every strobe must match the next expected nibble.
  always @(negedge tb04_clk) begin
    if (rst) begin
      prev_wo = 1'b0;
    end else begin
      if (bus.tx_wo) begin
        tx_cnt++;
        n_tests++;
        if (prev_wo) begin
          n_fail++;
          $display("FAIL tx_wo_width: strobe high two cycles in a row");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got nib 0x%0h, expected no strobe", bus.tx_nib);
        end else begin
          logic [3:0] e;
          e = sb.pop_front();
          if (bus.tx_nib !== e) begin
            n_fail++;
            $display("FAIL tx_nib: got 0x%0h, expected 0x%0h", bus.tx_nib, e);
          end
        end
      end
      prev_wo = bus.tx_wo;
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int lat, gap, base, k;

    vecs[0] = '{4'h4, 4'h1, 3, 2, 2};
    vecs[1] = '{4'hA, 4'h5, 1, 2, 2};
    vecs[2] = '{4'hF, 4'h0, 5, 2, 2};
    vecs[3] = '{4'h0, 4'hF, 2, 2, 2};

    bus.cpu_wo    = 1'b0;
    bus.cpu_out   = 4'h0;
    bus.uart_busy = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge tb04_clk);
    #2;
    check("rst_tx_wo", int'(bus.tx_wo), 0);
    check("rst_tx_nib", int'(bus.tx_nib), 0);
    check("rst_level", int'(bus.fifo_level), 0);
    check("rst_empty", int'(bus.fifo_empty), 1);
    check("rst_full", int'(bus.fifo_full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Single bytes: latency and hi/lo spacing
    for (int v = 0; v < 4; v++) begin
      sb.push_back(vecs[v].hi);
      sb.push_back(vecs[v].lo);
      send_nib(vecs[v].hi);
      repeat (vecs[v].spacing - 1) tick();
      send_nib(vecs[v].lo);
      lat = -1;
      for (k = 1; k <= 30; k++) begin
        @(negedge tb04_clk);
        if (bus.tx_wo) begin lat = k; break; end
      end
      check("first_strobe_latency", lat, vecs[v].exp_lat);
      gap = 0;
      for (k = 0; k < 30; k++) begin
        @(negedge tb04_clk);
        if (bus.tx_wo) break;
        gap++;
      end
      check("hi_lo_gap", gap, vecs[v].exp_gap);
      tick();
      repeat (12) tick();
      check("single_empty_after", int'(bus.fifo_empty), 1);
      check("single_sb_empty", sb.size(), 0);
    end

    // Burst while busy: 16 fit, 17th dropped
    bus.uart_busy = 1'b1;
    repeat (3) tick();
    base = tx_cnt;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i < 16) begin
        sb.push_back(b[7:4]);
        sb.push_back(b[3:0]);
      end
      send_nib(b[7:4]);
      send_nib(b[3:0]);
      if (i == 15) begin
        check("burst_full_at_16", int'(bus.fifo_full), 1);
        check("burst_no_ovf_at_16", int'(bus.overflow), 0);
      end
    end
    check("burst_level", int'(bus.fifo_level), 16);
    check("burst_overflow", int'(bus.overflow), 1);
    check("burst_no_tx", tx_cnt, base);
    bus.uart_busy = 1'b0;
    drain(400);
    check("overflow_sticky", int'(bus.overflow), 1);

    // Reset while in GAP
    base = tx_cnt;
    sb.push_back(4'hE);
    send_nib(4'hE);
    send_nib(4'h7);
    wait_tx(base + 1, 30);
    @(posedge tb04_clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_tx_wo", int'(bus.tx_wo), 0);
    check("rst_mid_level", int'(bus.fifo_level), 0);
    check("rst_mid_overflow", int'(bus.overflow), 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("no_lo_after_reset", tx_cnt, base + 1);
    sb.push_back(4'h3);
    sb.push_back(4'hC);
    send_nib(4'h3);
    send_nib(4'hC);
    drain(100);

    // Full FIFO: push collides with IDLE pop
    bus.uart_busy = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'h80 + 8'(i);
      sb.push_back(b[7:4]);
      sb.push_back(b[3:0]);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
    end
    send_nib(4'hD);
    sb.push_back(4'hD);
    sb.push_back(4'h2);
    bus.uart_busy = 1'b0;
    tick();
    tick();
    send_nib(4'h2);
    check("collide_level", int'(bus.fifo_level), 16);
    check("collide_overflow", int'(bus.overflow), 0);
    drain(400);

    // Busy gating after LO strobe
    base = tx_cnt;
    sb.push_back(4'h9); sb.push_back(4'h6);
    sb.push_back(4'hA); sb.push_back(4'h5);
    send_nib(4'h9); send_nib(4'h6);
    send_nib(4'hA); send_nib(4'h5);
    wait_tx(base + 2, 40);
    @(posedge tb04_clk);
    #1 bus.uart_busy = 1'b1;
    repeat (50) tick();
    check("busy_blocks_tx", tx_cnt, base + 2);
    check("busy_byte_queued", int'(bus.fifo_level), 1);
    bus.uart_busy = 1'b0;
    lat = -1;
    for (k = 1; k <= 30; k++) begin
      @(negedge tb04_clk);
      if (bus.tx_wo) begin lat = k; break; end
    end
    check("busy_release_latency", lat, 4);
    tick();
    drain(100);

    // Lost nibble: half-byte timeout behaviour
`ifdef TB04_NIB_RESYNC_EN
    send_nib(4'h7);
    repeat (10) tick();
    sb.push_back(4'h4);
    sb.push_back(4'h2);
    send_nib(4'h4);
    send_nib(4'h2);
    drain(100);
`else
    sb.push_back(4'h7);
    sb.push_back(4'h4);
    send_nib(4'h7);
    repeat (10) tick();
    send_nib(4'h4);
    send_nib(4'h2);
    drain(100);
    sb.push_back(4'h2);
    sb.push_back(4'h9);
    send_nib(4'h9);
    drain(100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
